// File: rtl/pc_gen_pkg.sv
// pc_gen shared types and constants.
// Redirect encodings, fetch step and BTB entry layout.
package pc_gen_pkg;

  localparam logic [1:0] REDIR_BRANCH = 2'b01;
  localparam logic [1:0] REDIR_TRAP   = 2'b10;
  localparam logic [1:0] REDIR_JALR   = 2'b11;

  localparam int unsigned PC_STEP = 4;

  // Entry fields sized for the widest supported PC (32 bits);
  // narrower tags are stored zero-extended.
  localparam int unsigned BTB_W = 32;

  typedef struct packed {
    logic             valid;
    logic [BTB_W-1:0] tag;
    logic [BTB_W-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen EX-side bus: redirect, BTB update and fetch outputs.
// master = EX/fetch control side, slave = pc_gen.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            en;
  logic            redir_valid;
  logic [1:0]      redir_mode;
  logic [XLEN-1:0] pc_ex;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] trap_vec;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [XLEN-1:0] pc_if;
  logic            pred_taken;
  logic            misalign;

  modport master (
    output en, redir_valid, redir_mode,
    output pc_ex, imm, rs1, trap_vec,
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  pc_if, pred_taken, misalign
  );

  modport slave (
    input  en, redir_valid, redir_mode,
    input  pc_ex, imm, rs1, trap_vec,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output pc_if, pred_taken, misalign
  );

endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer for pc_gen.
// Combinational lookup; writes land at posedge (old data seen that cycle).
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit,
  output logic [XLEN-1:0] target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int unsigned IDX = $clog2(BTB_ENTRIES);

  btb_entry_t       mem [BTB_ENTRIES];
  btb_entry_t       r_ent;
  logic [IDX-1:0]   r_idx;
  logic [IDX-1:0]   w_idx;
  logic [BTB_W-1:0] r_tag;
  logic [BTB_W-1:0] w_tag;
  logic             unused_lo;

  assign r_idx = lookup_pc[IDX+1:2];
  assign w_idx = upd_pc[IDX+1:2];
  assign r_tag = BTB_W'(lookup_pc[XLEN-1:IDX+2]);
  assign w_tag = BTB_W'(upd_pc[XLEN-1:IDX+2]);

  // Word-aligned indexing never looks at the byte offset.
  assign unused_lo = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign r_ent  = mem[r_idx];
  assign hit    = r_ent.valid && (r_ent.tag == r_tag);
  assign target = r_ent.target[XLEN-1:0];

  // Install on taken, drop only our own tag on not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++)
        mem[i] <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        mem[w_idx] <= '{
          valid:  1'b1,
          tag:    w_tag,
          target: BTB_W'(upd_target)
        };
      end else if (mem[w_idx].tag == w_tag) begin
        mem[w_idx].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage PC register with next-PC select and optional BTB.
// Define PC_GEN_BTB_EN to build the branch target buffer.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BTB_ENTRIES  = 16
) (
  input logic     clk,
  input logic     rst_n,
  pc_gen_if.slave bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            mis_q;
  logic [XLEN-1:0] btb_tgt;
  logic            btb_hit;
  logic            sel_trap;
  logic            sel_br;
  logic            sel_jalr;
  logic            sel_pred;
  logic            sel_seq;
  logic            is_redir;

  assign sel_trap = bus.redir_valid
                 && (bus.redir_mode == REDIR_TRAP);
  assign sel_br   = bus.redir_valid
                 && (bus.redir_mode == REDIR_BRANCH);
  assign sel_jalr = bus.redir_valid
                 && (bus.redir_mode == REDIR_JALR);
  assign is_redir = sel_trap | sel_br | sel_jalr;
  assign sel_pred = !is_redir && bus.en && btb_hit;
  assign sel_seq  = !is_redir && bus.en && !btb_hit;

  // Next-PC select; the selects are already priority-resolved.
  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      sel_trap: pc_d = bus.trap_vec;
      sel_br:   pc_d = bus.pc_ex + bus.imm;
      sel_jalr: pc_d = (bus.rs1 + bus.imm) & ~XLEN'(1);
      sel_pred: pc_d = btb_tgt;
      sel_seq:  pc_d = pc_q + XLEN'(PC_STEP);
      default:  pc_d = pc_q;
    endcase
  end

  // PC and its alignment flag move together; a hold reloads itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= (pc_d[1:0] != 2'b00);
    end
  end

`ifdef PC_GEN_BTB_EN
  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_pc  (pc_q),
    .hit        (btb_hit),
    .target     (btb_tgt),
    .upd_valid  (bus.upd_valid),
    .upd_pc     (bus.upd_pc),
    .upd_target (bus.upd_target),
    .upd_taken  (bus.upd_taken)
  );
`else
  logic unused_upd;

  assign btb_hit    = 1'b0;
  assign btb_tgt    = '0;
  assign unused_upd = ^{bus.upd_valid, bus.upd_pc,
                        bus.upd_target, bus.upd_taken};
`endif

  assign bus.pc_if      = pc_q;
  assign bus.pred_taken = btb_hit;
  assign bus.misalign   = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen (RESET_VECTOR=0x100, 16-entry BTB).
// Expectations follow the PC_GEN_BTB_EN setting of the build.
`timescale 1ns/1ps
module tb_pc_gen;

`ifdef PC_GEN_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) bus();

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .BTB_ENTRIES  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic        pred;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc;
  logic        m_mis;
  logic        mv   [16];
  logic [25:0] mtag [16];
  logic [31:0] mtgt [16];

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_hit(logic [31:0] pc);
    logic h;
    h = mv[pc[5:2]] && (mtag[pc[5:2]] == pc[31:6]);
`ifndef PC_GEN_BTB_EN
    h = 1'b0;
`endif
    return h;
  endfunction

  task automatic m_reset();
    m_pc  = 32'h100;
    m_mis = 1'b0;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic drv(logic en, logic rv, logic [1:0] md,
                     logic [31:0] a, logic [31:0] b);
    bus.en          = en;
    bus.redir_valid = rv;
    bus.redir_mode  = md;
    bus.pc_ex       = a;
    bus.rs1         = a;
    bus.trap_vec    = a;
    bus.imm         = b;
  endtask

  task automatic upd(logic v, logic [31:0] pc,
                     logic [31:0] tgt, logic tk);
    bus.upd_valid  = v;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = tk;
  endtask

  // Predict the next edge, push it, then compare after the edge.
  task automatic cyc(string tag);
    logic [31:0] nxt;
    logic [3:0]  ix;
    exp_t        e;
    if (bus.redir_valid && bus.redir_mode == 2'b10)
      nxt = bus.trap_vec;
    else if (bus.redir_valid && bus.redir_mode == 2'b01)
      nxt = bus.pc_ex + bus.imm;
    else if (bus.redir_valid && bus.redir_mode == 2'b11)
      nxt = (bus.rs1 + bus.imm) & 32'hFFFF_FFFE;
    else if (bus.en && m_hit(m_pc))
      nxt = mtgt[m_pc[5:2]];
    else if (bus.en)
      nxt = m_pc + 32'd4;
    else
      nxt = m_pc;
    if (bus.upd_valid) begin
      ix = bus.upd_pc[5:2];
      if (bus.upd_taken) begin
        mv[ix]   = 1'b1;
        mtag[ix] = bus.upd_pc[31:6];
        mtgt[ix] = bus.upd_target;
      end else if (mtag[ix] == bus.upd_pc[31:6]) begin
        mv[ix] = 1'b0;
      end
    end
    m_mis = (nxt[1:0] != 2'b00);
    m_pc  = nxt;
    sb.push_back('{m_pc, m_mis, m_hit(m_pc)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".pc"},   64'(bus.pc_if),      64'(e.pc));
    check({tag, ".mis"},  64'(bus.misalign),   64'(e.mis));
    check({tag, ".pred"}, 64'(bus.pred_taken), 64'(e.pred));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    drv(0, 0, 2'b00, 0, 0);
    upd(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      mtag[i] = '0;
      mtgt[i] = '0;
    end
    m_reset();
    #8;
    check("rst.pc",   64'(bus.pc_if),      64'h100);
    check("rst.mis",  64'(bus.misalign),   64'h0);
    check("rst.pred", 64'(bus.pred_taken), 64'h0);
    #4;
    rst_n = 1'b1;

    drv(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) cyc("seq");
    check("seq.end", 64'(bus.pc_if), 64'h10C);

    drv(0, 1, 2'b01, 32'h200, 32'h40);
    cyc("br_stall");
    check("br.pc", 64'(bus.pc_if), 64'h240);

    drv(0, 1, 2'b11, 32'h1001, 32'h4);
    cyc("jalr");
    check("jalr.pc", 64'(bus.pc_if), 64'h1004);

    drv(0, 1, 2'b11, 32'h1002, 32'h0);
    cyc("jalr_mis");
    check("jalr_mis.flag", 64'(bus.misalign), 64'h1);

    drv(0, 0, 2'b00, 0, 0);
    cyc("hold1");
    cyc("hold2");
    check("hold.pc",  64'(bus.pc_if),    64'h1002);
    check("hold.mis", 64'(bus.misalign), 64'h1);
    drv(1, 0, 2'b00, 0, 0);
    cyc("mis_seq");

    drv(0, 1, 2'b01, 32'h100, 32'h0);
    upd(1, 32'h108, 32'h300, 1);
    cyc("install");
    upd(0, 0, 0, 0);
    drv(1, 0, 2'b00, 0, 0);
    cyc("to104");
    cyc("to108");
    check("hit.pred", 64'(bus.pred_taken), 64'(BTB));
    cyc("pred_jump");
    check("pred.pc", 64'(bus.pc_if), BTB ? 64'h300 : 64'h10C);

    drv(0, 1, 2'b01, 32'h108, 32'h0);
    cyc("back108");
    drv(1, 1, 2'b10, 32'h80, 32'h0);
    cyc("trap_vs_hit");
    check("trap.pc", 64'(bus.pc_if), 64'h80);

    drv(0, 0, 2'b00, 0, 0);
    upd(1, 32'h148, 32'h0, 0);
    cyc("inv_miss");
    upd(0, 0, 0, 0);
    drv(0, 1, 2'b01, 32'h108, 32'h0);
    cyc("recheck");
    check("keep.pred", 64'(bus.pred_taken), 64'(BTB));

    drv(1, 0, 2'b00, 0, 0);
    upd(1, 32'h108, 32'h400, 1);
    cyc("war");
    check("war.pc", 64'(bus.pc_if), BTB ? 64'h300 : 64'h10C);
    upd(0, 0, 0, 0);
    drv(0, 1, 2'b01, 32'h108, 32'h0);
    cyc("back108b");
    drv(1, 0, 2'b00, 0, 0);
    cyc("new_tgt");
    check("new.pc", 64'(bus.pc_if), BTB ? 64'h400 : 64'h10C);

    drv(0, 1, 2'b01, 32'h108, 32'h0);
    upd(1, 32'h108, 32'h0, 0);
    cyc("inv_hit");
    upd(0, 0, 0, 0);
    drv(1, 0, 2'b00, 0, 0);
    cyc("after_inv");
    check("inv.pc", 64'(bus.pc_if), 64'h10C);

    drv(0, 1, 2'b10, 32'hFFFF_FFFC, 32'h0);
    cyc("to_top");
    drv(1, 0, 2'b00, 0, 0);
    cyc("wrap");
    check("wrap.pc", 64'(bus.pc_if), 64'h0);

    drv(0, 0, 2'b00, 0, 0);
    upd(1, 32'h108, 32'h300, 1);
    cyc("reinstall");
    upd(0, 0, 0, 0);

    drv(0, 1, 2'b01, 32'h500, 32'h0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("arst.pc",   64'(bus.pc_if),      64'h100);
    check("arst.mis",  64'(bus.misalign),   64'h0);
    check("arst.pred", 64'(bus.pred_taken), 64'h0);
    @(posedge clk);
    #1;
    check("arst_hold.pc", 64'(bus.pc_if), 64'h100);
    rst_n = 1'b1;
    drv(1, 0, 2'b00, 0, 0);
    cyc("post_rst1");
    cyc("post_rst2");
    check("cleared.pred", 64'(bus.pred_taken), 64'h0);
    cyc("post_rst3");
    check("cleared.pc", 64'(bus.pc_if), 64'h10C);

    check("sb.empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
